// File: rtl/framebuffer_ram_arbiter.sv
// Read-priority arbiter for the single-port framebuffer RAM, with a starvation guard for the loader.
// Optional write-stall statistics counter is built when ARB_STATS_EN is defined.
module framebuffer_ram_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_clk_enable,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [1:0]            grant,
    output logic [15:0]           wr_stall_count
);

    typedef enum logic [1:0] {
        GRANT_IDLE = 2'b00,
        GRANT_RD   = 2'b01,
        GRANT_WR   = 2'b10
    } grant_e;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    grant_e                  grant_q,     grant_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    ram_we_q,    ram_we_d;
    logic                    ram_ce_q,    ram_ce_d;
    logic [7:0]              starve_q,    starve_d;
    logic [1:0]              rd_pipe_q,   rd_pipe_d;
    logic                    rd_valid_q,  rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,   rd_data_d;

    logic force_wr_s;
    logic rd_grant_s;
    logic wr_grant_s;

    // Arbitration: reads win unless a waiting write has been starved for STARVE_LIMIT grants
    always_comb begin
        force_wr_s = wr_valid && (starve_q == STARVE_MAX);
        rd_ready   = !force_wr_s;
        wr_ready   = force_wr_s || !rd_req;
        rd_grant_s = rd_req && !force_wr_s;
        wr_grant_s = !rd_grant_s && wr_valid && wr_ready;
    end

    // Next-state for RAM pins, grant, starvation counter and the two-stage read return pipe
    always_comb begin
        grant_d     = GRANT_IDLE;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        ram_ce_d    = 1'b0;
        starve_d    = starve_q;
        if (rd_grant_s) begin
            grant_d    = GRANT_RD;
            ram_addr_d = rd_addr;
            ram_ce_d   = 1'b1;
        end else if (wr_grant_s) begin
            grant_d     = GRANT_WR;
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
            ram_we_d    = 1'b1;
            ram_ce_d    = 1'b1;
        end else begin
            grant_d = GRANT_IDLE;
        end

        if (wr_grant_s || !wr_valid) begin
            starve_d = 8'd0;
        end else if (rd_grant_s && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end

        // Stage 0: address registered to the RAM; stage 1: RAM has sampled, data appears next edge
        rd_pipe_d  = {rd_pipe_q[0], rd_grant_s};
        rd_valid_d = rd_pipe_q[1];
        if (rd_pipe_q[1]) begin
            rd_data_d = ram_rdata;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            grant_q     <= GRANT_IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_ce_q    <= 1'b0;
            starve_q    <= 8'd0;
            rd_pipe_q   <= 2'b00;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            grant_q     <= grant_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_ce_q    <= ram_ce_d;
            starve_q    <= starve_d;
            rd_pipe_q   <= rd_pipe_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of cycles in which the loader is held off
    always_comb begin
        if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign wr_stall_count = stall_q;
`else
    assign wr_stall_count = 16'd0;
`endif

    assign grant          = grant_q;
    assign ram_addr       = ram_addr_q;
    assign ram_wdata      = ram_wdata_q;
    assign ram_we         = ram_we_q;
    assign ram_clk_enable = ram_ce_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_framebuffer_ram_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level reference model.
module tb_framebuffer_ram_arbiter;

    localparam int STARVE_LIMIT = 8;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b1;
    logic        rd_req = 1'b0;
    logic [10:0] rd_addr = 11'd0;
    logic        rd_ready;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_valid = 1'b0;
    logic [10:0] wr_addr = 11'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_ready;
    logic [10:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic        ram_clk_enable;
    logic [15:0] ram_rdata = 16'd0;
    logic [1:0]  grant;
    logic [15:0] wr_stall_count;

    framebuffer_ram_arbiter #(
        .ADDR_WIDTH(11), .DATA_WIDTH(16), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_clk_enable(ram_clk_enable), .ram_rdata(ram_rdata),
        .grant(grant), .wr_stall_count(wr_stall_count)
    );

    always #5 clk_in = ~clk_in;

    // Write-first synchronous RAM macro
    logic [15:0] ram_mem [0:2047];
    always @(posedge clk_in) begin
        if (ram_clk_enable) begin
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_wdata;
                ram_rdata         <= ram_wdata;
            end else begin
                ram_rdata <= ram_mem[ram_addr];
            end
        end
    end

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_exp_t;

    // Reference model state
    logic [15:0] shadow [0:2047];
    rd_exp_t     exp_q[$];
    int          edge_n = 0;
    int          m_starve = 0;
    logic [1:0]  m_grant = 2'b00;
    logic [10:0] m_addr = 11'd0;
    logic [15:0] m_wdata = 16'd0;
    logic        m_we = 1'b0;
    logic        m_ce = 1'b0;
    logic [15:0] m_last = 16'd0;
    logic [15:0] m_stall = 16'd0;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_stall();
`ifdef ARB_STATS_EN
        return m_stall;
`else
        return 16'd0;
`endif
    endfunction

    task automatic apply_reset();
        rd_req = 1'b0; wr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        m_starve = 0; m_grant = 2'b00; m_addr = 11'd0; m_wdata = 16'd0;
        m_we = 1'b0; m_ce = 1'b0; m_last = 16'd0; m_stall = 16'd0;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
        check_eq("rst_ram_wdata", 32'(ram_wdata), 32'h0);
        check_eq("rst_ram_we", 32'(ram_we), 32'h0);
        check_eq("rst_ram_ce", 32'(ram_clk_enable), 32'h0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
        check_eq("rst_rd_data", 32'(rd_data), 32'h0);
        check_eq("rst_stall", 32'(wr_stall_count), 32'h0);
        @(posedge clk_in);
        @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    // One clock of stimulus; predicts handshakes and all registered outputs from the arbitration rules
    task automatic drive_cycle(input logic rq, input logic [10:0] ra, input logic wv,
                               input logic [10:0] wa, input logic [15:0] wd,
                               output logic acc_rd, output logic acc_wr);
        logic force_w, e_rrdy, e_wrdy, e_valid;
        rd_req = rq; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
        #1;
        force_w = wv && (m_starve == STARVE_LIMIT);
        e_rrdy  = !force_w;
        e_wrdy  = force_w || !rq;
        check_eq("rd_ready", 32'(rd_ready), 32'(e_rrdy));
        check_eq("wr_ready", 32'(wr_ready), 32'(e_wrdy));
        acc_rd = rq && e_rrdy;
        acc_wr = !acc_rd && wv && e_wrdy;
        @(posedge clk_in);
        edge_n++;
        if (wv && !e_wrdy && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        if (acc_rd) begin
            exp_q.push_back('{edge_n + 2, shadow[ra]});
            m_grant = 2'b01; m_addr = ra; m_we = 1'b0; m_ce = 1'b1;
        end else if (acc_wr) begin
            shadow[wa] = wd;
            m_grant = 2'b10; m_addr = wa; m_wdata = wd; m_we = 1'b1; m_ce = 1'b1;
        end else begin
            m_grant = 2'b00; m_we = 1'b0; m_ce = 1'b0;
        end
        if (acc_rd && wv) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
        else if (acc_wr || !wv) m_starve = 0;
        e_valid = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
        if (e_valid) begin
            m_last = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        #1;
        check_eq("grant", 32'(grant), 32'(m_grant));
        check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
        check_eq("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
        check_eq("ram_we", 32'(ram_we), 32'(m_we));
        check_eq("ram_ce", 32'(ram_clk_enable), 32'(m_ce));
        check_eq("rd_valid", 32'(rd_valid), 32'(e_valid));
        check_eq("rd_data", 32'(rd_data), 32'(m_last));
        check_eq("stall_cnt", 32'(wr_stall_count), 32'(exp_stall()));
        @(negedge clk_in);
    endtask

    task automatic idle(input int n);
        logic ar, aw;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 11'd0, 1'b0, 11'd0, 16'd0, ar, aw);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ar, aw;
        logic        pend_wv;
        logic [10:0] pend_wa;
        logic [15:0] pend_wd;
        int rd_before, wr_seen;

        for (int i = 0; i < 2048; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            ram_mem[i] <= v;
            shadow[i] = v;
        end
        ram_mem[11'h045] <= 16'hF800;
        shadow[11'h045] = 16'hF800;

        #2;
        apply_reset();

        // Reset mid-read: accepted read must never return
        drive_cycle(1'b1, 11'h123, 1'b0, 11'd0, 16'd0, ar, aw);
        check_eq("mr_accept", 32'(ar), 32'h1);
        apply_reset();
        idle(4);

        // Single read of 0x045
        drive_cycle(1'b1, 11'h045, 1'b0, 11'd0, 16'd0, ar, aw);
        check_eq("sr_addr", 32'(ram_addr), 32'h045);
        check_eq("sr_ce", 32'(ram_clk_enable), 32'h1);
        idle(1);
        check_eq("sr_early", 32'(rd_valid), 32'h0);
        idle(1);
        check_eq("sr_valid", 32'(rd_valid), 32'h1);
        check_eq("sr_data", 32'(rd_data), 32'hF800);
        idle(1);
        check_eq("sr_pulse", 32'(rd_valid), 32'h0);
        check_eq("sr_hold", 32'(rd_data), 32'hF800);

        // Idle write then read-back of the same word
        drive_cycle(1'b0, 11'd0, 1'b1, 11'h7FF, 16'h07E0, ar, aw);
        check_eq("iw_grant", 32'(grant), 32'h2);
        check_eq("iw_we", 32'(ram_we), 32'h1);
        check_eq("iw_addr", 32'(ram_addr), 32'h7FF);
        check_eq("iw_wdata", 32'(ram_wdata), 32'h07E0);
        drive_cycle(1'b1, 11'h7FF, 1'b0, 11'd0, 16'd0, ar, aw);
        idle(2);
        check_eq("iw_readback", 32'(rd_data), 32'h07E0);

        // Starvation: continuous reads with a pending write
        apply_reset();
        rd_before = 0; wr_seen = 0; pend_wv = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b1, 11'(i), pend_wv, 11'h100, 16'hBEEF, ar, aw);
            if (aw) pend_wv = 1'b0;
            if (grant == 2'b01 && wr_seen == 0) rd_before++;
            if (grant == 2'b10) wr_seen++;
        end
        check_eq("sv_reads_before", 32'(rd_before), 32'(STARVE_LIMIT));
        check_eq("sv_writes", 32'(wr_seen), 32'h1);
`ifdef ARB_STATS_EN
        check_eq("sv_stall8", 32'(wr_stall_count), 32'd8);
`else
        check_eq("sv_stall0", 32'(wr_stall_count), 32'd0);
`endif
        drive_cycle(1'b1, 11'h100, 1'b0, 11'd0, 16'd0, ar, aw);
        idle(2);
        check_eq("sv_readback", 32'(rd_data), 32'hBEEF);

        // Short read burst contending with a write
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 11'(16 + i), 1'b1, 11'h200, 16'h1234, ar, aw);
            check_eq("sb_rgrant", 32'(grant), 32'h1);
        end
        drive_cycle(1'b0, 11'd0, 1'b1, 11'h200, 16'h1234, ar, aw);
        check_eq("sb_wgrant", 32'(grant), 32'h2);
        idle(3);

        // Random traffic on a small address window to force read/write collisions
        pend_wv = 1'b0; pend_wa = 11'd0; pend_wd = 16'd0;
        for (int i = 0; i < 1500; i++) begin
            if (!pend_wv && ($urandom_range(0, 3) == 0)) begin
                pend_wv = 1'b1;
                pend_wa = 11'($urandom_range(0, 15));
                pend_wd = 16'($urandom);
            end
            drive_cycle($urandom_range(0, 9) < 7, 11'($urandom_range(0, 15)),
                        pend_wv, pend_wa, pend_wd, ar, aw);
            if (aw) pend_wv = 1'b0;
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/framebuffer_ram_arbiter.md
Name: framebuffer_ram_arbiter

Overview:
Shares the single-port framebuffer RAM (11-bit address, 16-bit data) between two requesters. The display pixel-fetch path reads; the frame loader (UART/SPI-side writer) writes. Reads have priority. A starvation guard forces a write slot after a bounded run of read grants while a write is waiting. The block sits between the fetch logic, the loader, and the RAM macro, and owns the RAM address, write-enable and clock-enable pins.

Parameters:
ADDR_WIDTH, 11, RAM address width.
DATA_WIDTH, 16, RAM word width (rgb565).
STARVE_LIMIT, 8, consecutive read grants allowed while wr_valid is pending before one write is forced; range 1..255.

Ports:
clk_in  input  1  system clock; all logic on posedge.
reset_n  input  1  asynchronous, active-low reset.
rd_req  input  1  read request; sampled on the same edge as rd_addr.
rd_addr  input  ADDR_WIDTH  read address.
rd_ready  output  1  combinational; rd_req is accepted only when rd_ready=1.
rd_valid  output  1  one-cycle pulse; rd_data is valid.
rd_data  output  DATA_WIDTH  read data; held until the next rd_valid.
wr_valid  input  1  write request; must stay asserted with stable wr_addr/wr_data until accepted.
wr_addr  input  ADDR_WIDTH  write address.
wr_data  input  DATA_WIDTH  write data.
wr_ready  output  1  combinational; a write is accepted on an edge where wr_valid&&wr_ready.
ram_addr  output  ADDR_WIDTH  registered RAM address.
ram_wdata  output  DATA_WIDTH  registered RAM write data.
ram_we  output  1  registered RAM write enable.
ram_clk_enable  output  1  registered; high for every granted access.
ram_rdata  input  DATA_WIDTH  RAM read data; valid one edge after the RAM samples its address.
grant  output  2  registered: 00 idle, 01 read, 10 write.
wr_stall_count  output  16  see Optional Feature.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - ram_addr, ram_wdata, rd_data, wr_stall_count = 0.
  - ram_we, ram_clk_enable, rd_valid = 0; grant = 00.
  - Starve counter = 0; read pipeline flags cleared.
  - A read in flight when reset asserts never produces rd_valid.
- Arbitration, combinational per cycle:
  - force_wr = wr_valid && (starve_cnt == STARVE_LIMIT).
  - rd_ready = !force_wr.
  - wr_ready = force_wr || !rd_req.
- Grant, registered at each edge:
  - rd_req && rd_ready: grant=01; ram_addr=rd_addr; ram_we=0; ram_clk_enable=1.
  - Else if wr_valid && wr_ready: grant=10; ram_addr=wr_addr; ram_wdata=wr_data; ram_we=1; ram_clk_enable=1.
  - Else: grant=00; ram_we=0; ram_clk_enable=0; ram_addr and ram_wdata hold.
- Starve counter:
  - Read granted while wr_valid=1: increment, saturating at STARVE_LIMIT.
  - Write granted, or wr_valid=0: clear to 0.
- Read latency:
  - Request accepted at edge k; RAM samples its address at edge k+1; ram_rdata is captured into rd_data at edge k+2.
  - rd_valid is high during the cycle following edge k+2.
  - Fully pipelined: back-to-back reads give back-to-back rd_valid pulses.
- Write is fire-and-forget: the RAM commits it at edge k+1. No completion pulse.
- Ordering: a read of an address accepted the cycle after a write to that address returns the new data (RAM write-first behaviour required of the macro).
- Simultaneous rd_req and wr_valid, not starved: read wins and the writer stalls.
- Starved: the write wins for exactly one cycle, rd_ready=0 that cycle, and the reader must hold its request.
- wr_valid dropping before acceptance is a protocol violation. The arbiter simply drops the request and clears the starve counter.

Optional Feature:
ARB_STATS_EN
- Defined: wr_stall_count is a 16-bit counter, saturating at 0xFFFF. It increments on every cycle with wr_valid=1 && wr_ready=0 and clears only on reset.
- Undefined: wr_stall_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset mid-read: rd_req to 0x123 accepted, reset_n pulsed low 1 cycle later -> no rd_valid; all outputs at reset values; grant=00.
- Single read: ram model holds 0xF800 at 0x045; rd_req 1 cycle with rd_addr=0x045 -> ram_addr=0x045, ram_clk_enable=1 one edge later; rd_valid pulse 2 edges after acceptance; rd_data=0xF800 and held afterward.
- Idle write: wr_valid with 0x7FF/0x07E0, rd_req=0 -> wr_ready=1; next cycle ram_we=1, ram_addr=0x7FF, ram_wdata=0x07E0, grant=10; a read of 0x7FF then returns 0x07E0.
- Starvation, STARVE_LIMIT=8: rd_req held high continuously and wr_valid held -> 8 read grants, then one write grant with rd_ready=0 that cycle, then reads resume; the write lands exactly once.
- Contention with a short read burst: 3 reads concurrent with wr_valid -> 3 read grants, then the write grants on the first cycle with rd_req=0; starve counter back to 0.
- ARB_STATS_EN defined: the 8-read starvation scenario -> wr_stall_count=8. Undefined: wr_stall_count stays 0.
